measure_scheduler: RTL
======================

Name: measure_scheduler

Overview:
- Multi-channel measurement scheduler for the ADC front end.
- Selects one enabled ADC channel at a time and waits a settle interval after each switch.
- Paces a fixed-length sampling window with a programmable divider, then reports per-channel peak-to-peak (vpp) and DC offset (midpoint of min/max).
- Sits between the ADC capture registers and the DC-removal/display logic; the latched per-channel DC table feeds downstream offset subtraction.

Parameters:
- N, 8, ADC sample width (unsigned).
- CHANNELS, 4, number of ADC channels.
- CH_W, 2, channel index width, equal to clog2(CHANNELS).
- SAMPLE_POINTS, 8, samples per measurement window.
- LOG_2_SAMPLE_POINTS, 3, clog2(SAMPLE_POINTS).
- SETTLE_CYC, 4, clk cycles to wait after a channel switch (minimum 1).
- DIV_W, 16, width of the sample divider.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  stop the sweep immediately.
- cont  in  1  repeat the sweep continuously; sampled at end of each sweep.
- ch_mask  in  CHANNELS  enabled channels; latched at start.
- sample_div  in  DIV_W  sample period minus 1, in clk cycles; latched at start.
- adc_data  in  CHANNELS*N  packed unsigned samples; channel c occupies bits [c*N +: N].
- busy  out  1  sweep in progress.
- ch_sel  out  CH_W  channel currently measured (drives the analog mux).
- res_valid  out  1  one-cycle pulse; res_* outputs are valid.
- res_ch  out  CH_W  channel of the result.
- res_vpp  out  N  max-min over the window.
- res_dc  out  N  (max+min)>>1 over the window.
- dc_table  out  CHANNELS*N  last res_dc per channel.
- done  out  1  one-cycle pulse at end of sweep.

Behaviour:
- Reset: all outputs 0, state IDLE, dc_table 0. Reset mid-sweep drops all partial results.
- States:
  - IDLE: busy=0. If start=1 and ch_mask!=0: latch mask and divider, set ch_sel to the lowest set bit, go to SETTLE. If start=1 and ch_mask==0: pulse done on the next cycle, no results, stay IDLE.
  - SETTLE: lasts exactly SETTLE_CYC cycles. Clears the tracker (max=0, min=all-ones) and the sample counter, then goes to SAMPLE.
  - SAMPLE: the divider counter runs 0..D, where D = latched sample_div. When the counter equals D, take adc_data[ch_sel] into the tracker and increment the sample count. D=0 means a sample every cycle. After SAMPLE_POINTS samples, go to REPORT.
  - REPORT: one cycle. res_valid=1; res_ch=ch_sel; res_vpp=max-min; res_dc = bits [N:1] of the (N+1)-bit sum max+min (no overflow). Update dc_table[res_ch]. If a higher set bit exists in the latched mask, set ch_sel to it and go to SETTLE; otherwise go to END.
  - END: one cycle. done=1. If cont=1, relatch ch_mask/sample_div and restart at SETTLE with the lowest set bit; a zero mask goes to IDLE instead. If cont=0, go to IDLE.
- busy: 1 in SETTLE, SAMPLE and REPORT; 0 in IDLE and END.
- Timing (start high at cycle t0): busy rises at t0+1. SAMPLE starts at S = t0+1+SETTLE_CYC. Samples are taken at S + k(D+1) + D for k = 0..SAMPLE_POINTS-1. res_valid fires at S + SAMPLE_POINTS(D+1).
- abort (any state): next state IDLE. No res_valid, no done. dc_table keeps its contents. abort has priority over start and cont.
- start while busy: ignored. Changes to ch_mask/sample_div during a sweep have no effect until the next latch.
- Min/max comparisons are unsigned. Equal values do not update. A constant input gives vpp=0 and dc equal to that value.

Decomposition:
- Package measure_pkg: the state enum (IDLE, SETTLE, SAMPLE, REPORT, END) and a priority-encoder function "next set bit at or above index".
- Sub-module window_peak_tracker (N): clr, sample_en, din, outputs max and min.

Test Plan:
- CHANNELS=4, SETTLE_CYC=4, SAMPLE_POINTS=8, D=0, mask=4'b0101, ch0 fed ramp 10..17, ch2 fed constant 200 -> ch0 res_valid at t0+13 with vpp=7, dc=13; ch2 res_valid at t0+26 with vpp=0, dc=200; done at t0+27; dc_table ch0=13, ch2=200.
- D=2, mask=0001, ch0 fed samples 0 and 255 alternating on sample cycles -> samples at S+2, S+5, ...; res_valid at S+24; vpp=255, dc=127 (no sum overflow).
- mask=0000 with start -> done one cycle later, busy stays 0, no res_valid.
- abort asserted mid-SAMPLE on ch1 -> IDLE next cycle; no res_valid, no done; dc_table unchanged; a new start works normally.
- cont=1, mask=1000 -> repeated ch3 reports every SETTLE_CYC + 8(D+1) + 2 cycles, with a done pulse each sweep; dropping cont ends the run after the current sweep.
- rst_n low for one cycle mid-REPORT -> all outputs 0 on the next cycle, and dc_table cleared.

Source files
------------

// File: rtl/measure_scheduler_pkg.sv
// measure_scheduler_pkg: scheduler state encoding and channel priority encoder
package measure_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPORT, END} state_t;
  // Lowest set bit of mask at or above index from, or -1 when none remains
  function automatic int next_set(input logic [31:0] mask, input int from);
    next_set = -1;
    for (int i = 31; i >= 0; i--)
      if (i >= from && mask[i]) next_set = i;
  endfunction
endpackage

// File: rtl/measure_scheduler_if.sv
// measure_scheduler_if: control, ADC sample and result bundle of the scheduler
interface measure_scheduler_if #(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int DIV_W    = 16
);
  logic                  start;
  logic                  abort;
  logic                  cont;
  logic [CHANNELS-1:0]   ch_mask;
  logic [DIV_W-1:0]      sample_div;
  logic [CHANNELS*N-1:0] adc_data;
  logic                  busy;
  logic [CH_W-1:0]       ch_sel;
  logic                  res_valid;
  logic [CH_W-1:0]       res_ch;
  logic [N-1:0]          res_vpp;
  logic [N-1:0]          res_dc;
  logic [CHANNELS*N-1:0] dc_table;
  logic                  done;
  modport master (
    output start, abort, cont, ch_mask, sample_div, adc_data,
    input  busy, ch_sel, res_valid, res_ch, res_vpp, res_dc, dc_table, done
  );
  modport slave (
    input  start, abort, cont, ch_mask, sample_div, adc_data,
    output busy, ch_sel, res_valid, res_ch, res_vpp, res_dc, dc_table, done
  );
endinterface

// File: rtl/measure_scheduler_tracker.sv
// window_peak_tracker: running unsigned max/min of the samples in one window
module window_peak_tracker #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         sample_en,
  input  logic [N-1:0] din,
  output logic [N-1:0] max_val,
  output logic [N-1:0] min_val
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      max_val <= '0;
      min_val <= '1;
    end else if (sample_en) begin
      if (din > max_val) max_val <= din;
      if (din < min_val) min_val <= din;
    end
  end
endmodule

// File: rtl/measure_scheduler.sv
// measure_scheduler: sweeps enabled ADC channels, reporting vpp and DC per channel
module measure_scheduler
  import measure_pkg::*;
#(
  parameter int N                   = 8,
  parameter int CHANNELS            = 4,
  parameter int CH_W                = 2,
  parameter int SAMPLE_POINTS       = 8,
  parameter int LOG_2_SAMPLE_POINTS = 3,
  parameter int SETTLE_CYC          = 4,
  parameter int DIV_W               = 16
) (
  input logic               clk,
  input logic               rst_n,
  measure_scheduler_if.slave bus
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  state_t                         state, nxt;
  logic [CHANNELS-1:0]            lmask;
  logic [DIV_W-1:0]               ldiv, div_cnt;
  logic [LOG_2_SAMPLE_POINTS-1:0] smp_cnt;
  logic [SET_W-1:0]               set_cnt;
  logic [CH_W-1:0]                ch_sel, first_ch, next_ch;
  logic [CHANNELS*N-1:0]          dc_q;
  logic [N-1:0]                   din, max_val, min_val;
  logic [N:0]                     sum;
  logic                           empty_done, tick, take, last_smp, settle_done, has_next, rep;
  assign first_ch    = CH_W'(next_set(32'(bus.ch_mask), 0));
  assign next_ch     = CH_W'(next_set(32'(lmask), int'(ch_sel) + 1));
  assign has_next    = next_set(32'(lmask), int'(ch_sel) + 1) >= 0;
  assign settle_done = set_cnt == SET_W'(SETTLE_CYC - 1);
  assign tick        = div_cnt == ldiv;
  assign take        = state == SAMPLE && tick;
  assign last_smp    = smp_cnt == LOG_2_SAMPLE_POINTS'(SAMPLE_POINTS - 1);
  assign rep         = state == REPORT;
  assign din         = bus.adc_data[ch_sel*N +: N];
  // Widened sum keeps the carry so the midpoint never wraps
  assign sum         = {1'b0, max_val} + {1'b0, min_val};
  window_peak_tracker #(.N(N)) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == SETTLE),
    .sample_en(take),
    .din      (din),
    .max_val  (max_val),
    .min_val  (min_val)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start && |bus.ch_mask ? SETTLE : IDLE;
      SETTLE:  nxt = settle_done ? SAMPLE : SETTLE;
      SAMPLE:  nxt = take && last_smp ? REPORT : SAMPLE;
      REPORT:  nxt = has_next ? SETTLE : END;
      END:     nxt = bus.cont && |bus.ch_mask ? SETTLE : IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.abort) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lmask      <= '0;
      ldiv       <= '0;
      ch_sel     <= '0;
      div_cnt    <= '0;
      smp_cnt    <= '0;
      set_cnt    <= '0;
      dc_q       <= '0;
      empty_done <= 1'b0;
    end else begin
      empty_done <= state == IDLE && bus.start && !(|bus.ch_mask) && !bus.abort;
      set_cnt    <= state == SETTLE ? set_cnt + 1'b1 : '0;
      div_cnt    <= state == SAMPLE && !tick ? div_cnt + 1'b1 : '0;
      smp_cnt    <= state == SAMPLE ? smp_cnt + LOG_2_SAMPLE_POINTS'(take) : '0;
      if (nxt == SETTLE && (state == IDLE || state == END)) begin
        lmask  <= bus.ch_mask;
        ldiv   <= bus.sample_div;
        ch_sel <= first_ch;
      end else if (rep && nxt == SETTLE) begin
        ch_sel <= next_ch;
      end
      if (rep && !bus.abort) dc_q[ch_sel*N +: N] <= sum[N:1];
    end
  end
  assign bus.busy      = state == SETTLE || state == SAMPLE || rep;
  assign bus.ch_sel    = ch_sel;
  assign bus.res_valid = rep;
  assign bus.res_ch    = rep ? ch_sel : '0;
  assign bus.res_vpp   = rep ? max_val - min_val : '0;
  assign bus.res_dc    = rep ? sum[N:1] : '0;
  assign bus.dc_table  = dc_q;
  assign bus.done      = state == END || empty_done;
endmodule
